// File: rtl/config_loader_pkg.sv
// Shared types and constants for the tile-array configuration loader.
// Address layout on the config bus is {mod_id, tile_id}.
package config_loader_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned FIELD_W = 16;

    localparam int unsigned TILE_ID_LSB = 0;
    localparam int unsigned TILE_ID_MSB = 15;
    localparam int unsigned MOD_ID_LSB  = 16;
    localparam int unsigned MOD_ID_MSB  = 31;

    // Module flags decoded by the tiles; id 0 matches nothing.
    localparam logic [FIELD_W-1:0] MOD_CLB = 16'd4;
    localparam logic [FIELD_W-1:0] MOD_CB1 = 16'd5;
    localparam logic [FIELD_W-1:0] MOD_CB0 = 16'd6;
    localparam logic [FIELD_W-1:0] MOD_SB  = 16'd7;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_ERROR
    } loader_state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] mod_id;
        logic [FIELD_W-1:0] tile_id;
    } cfg_addr_t;

    function automatic logic is_valid_mod(input logic [FIELD_W-1:0] mod_id);
        return (mod_id >= MOD_CLB) && (mod_id <= MOD_SB);
    endfunction

endpackage

// File: rtl/config_loader_if.sv
// Word stream in and configuration bus out of the loader.
// master = stream source / bus observer, slave = the loader itself.
interface config_loader_if;
    import config_loader_pkg::*;

    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] config_addr;
    logic [WORD_W-1:0] config_data;
    logic              config_write;

    modport master (
        output in_data, in_valid,
        input  in_ready, config_addr, config_data, config_write
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, config_addr, config_data, config_write
    );

endinterface

// File: rtl/config_loader.sv
// Frame parser (header, address/data pairs, XOR checksum) driving the
// shared tile configuration bus with one single-cycle write per pair.
module config_loader
    import config_loader_pkg::*;
#(
    parameter logic [FIELD_W-1:0] MAGIC     = 16'hC0F1,
    parameter logic [WORD_W-1:0]  IDLE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    config_loader_if.slave   bus,
    output logic             busy,
    output logic             done,
    output logic             error
);

    loader_state_t      state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [WORD_W-1:0]  csum_q, csum_d;
    cfg_addr_t          addr_q, addr_d;
    logic [WORD_W-1:0]  cfg_addr_q, cfg_addr_d;
    logic [WORD_W-1:0]  cfg_data_q, cfg_data_d;
    logic               cfg_write_q, cfg_write_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               accept_c;

    assign accept_c = bus.in_valid && in_ready_q;

    // Next-state and datapath; bus outputs default to idle every cycle.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        csum_d      = csum_q;
        addr_d      = addr_q;
        cfg_addr_d  = IDLE_ADDR;
        cfg_data_d  = '0;
        cfg_write_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_HDR: begin
                if (accept_c) begin
                    if (bus.in_data[MOD_ID_MSB:MOD_ID_LSB] != MAGIC) begin
                        state_d = ST_ERROR;
                    end else begin
                        count_d = bus.in_data[COUNT_W-1:0];
                        csum_d  = '0;
                        state_d = (bus.in_data[COUNT_W-1:0] == '0) ? ST_CHECK : ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (accept_c) begin
                    addr_d  = cfg_addr_t'(bus.in_data);
                    csum_d  = csum_q ^ bus.in_data;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // Load the write straight into the output flops so it appears next cycle.
                if (accept_c) begin
                    csum_d      = csum_q ^ bus.in_data;
                    cfg_addr_d  = WORD_W'(addr_q);
                    cfg_data_d  = bus.in_data;
                    cfg_write_d = 1'b1;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                count_d = count_q - COUNT_W'(1);
                state_d = (count_q == COUNT_W'(1)) ? ST_CHECK : ST_ADDR;
            end
            ST_CHECK: begin
                if (accept_c) begin
                    if (bus.in_data == csum_q) begin
                        done_d  = 1'b1;
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                if (clear) begin
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase

        in_ready_d = (state_d != ST_WRITE) && (state_d != ST_ERROR);
        busy_d     = (state_d != ST_HDR) && (state_d != ST_ERROR);
        error_d    = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_HDR;
            count_q     <= '0;
            csum_q      <= '0;
            addr_q      <= '0;
            cfg_addr_q  <= IDLE_ADDR;
            cfg_data_q  <= '0;
            cfg_write_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            csum_q      <= csum_d;
            addr_q      <= addr_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            cfg_write_q <= cfg_write_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.config_addr  = cfg_addr_q;
    assign bus.config_data  = cfg_data_q;
    assign bus.config_write = cfg_write_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: frames, stalls, bad header/checksum,
// empty frames and mid-write reset.
module tb_config_loader;

    logic clk = 1'b0;
    logic reset;
    logic clear;
    logic busy, done, error;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int done_cnt   = 0;
    int idle_viol  = 0;
    int ready_viol = 0;

    always #5 clk = ~clk;

    config_loader_if ifc ();

    config_loader #(
        .MAGIC     (16'hC0F1),
        .IDLE_ADDR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (ifc.slave),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus monitor: records writes, flags non-idle bus and ready during writes.
    always @(negedge clk) begin
        if (reset) begin
            if (ifc.config_write) begin
                wr_addr_q.push_back(ifc.config_addr);
                wr_data_q.push_back(ifc.config_data);
                if (ifc.in_ready) ready_viol++;
            end else if (ifc.config_addr !== 32'h0 || ifc.config_data !== 32'h0) begin
                idle_viol++;
            end
            if (done) done_cnt++;
        end
    end

    // Present one word until accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [31:0] w, input bit rand_valid);
        int  waits = 0;
        bit  sent  = 1'b0;
        while (!sent) begin
            @(negedge clk);
            if (waits > 100) begin
                check("send_timeout", 32'd0, 32'd1);
                ifc.in_valid = 1'b0;
                return;
            end
            waits++;
            if (rand_valid && ($urandom_range(0, 1) == 0)) begin
                ifc.in_valid = 1'b0;
                ifc.in_data  = $urandom;
            end else begin
                ifc.in_valid = 1'b1;
                ifc.in_data  = w;
                if (ifc.in_ready) sent = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 32'hBAD0_BAD0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_error", 32'(error), 32'd0);
        check("clear_ready", 32'(ifc.in_ready), 32'd1);
    endtask

    task automatic expect_done(input string tag);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(error), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic check_writes(input string tag, input int n,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic [31:0] a2, input logic [31:0] d2);
        logic [31:0] ea[3];
        logic [31:0] ed[3];
        ea[0] = a0; ea[1] = a1; ea[2] = a2;
        ed[0] = d0; ed[1] = d1; ed[2] = d2;
        check({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check({tag, "_addr"}, wr_addr_q[i], ea[i]);
            check({tag, "_data"}, wr_data_q[i], ed[i]);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset        = 1'b0;
        clear        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ifc.in_ready), 32'd1);
        check("rst_write", 32'(ifc.config_write), 32'd0);
        check("rst_addr", ifc.config_addr, 32'h0);
        check("rst_data", ifc.config_data, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b1;

        // Single pair, with write/ready timing checked directly.
        send(32'hC0F1_0001, 1'b0);
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);
        send(32'h0004_0003, 1'b0);
        send(32'h0000_0002, 1'b0);
        @(negedge clk);
        check("t1_wr", 32'(ifc.config_write), 32'd1);
        check("t1_wr_ready", 32'(ifc.in_ready), 32'd0);
        check("t1_wr_addr", ifc.config_addr, 32'h0004_0003);
        check("t1_wr_data", ifc.config_data, 32'h0000_0002);
        send(32'h0004_0001, 1'b0);
        expect_done("t1");
        check_writes("t1", 1, 32'h0004_0003, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0);

        // Three pairs with random valid gaps.
        d0 = done_cnt;
        send(32'hC0F1_0003, 1'b1);
        send(32'h0005_0001, 1'b1);
        send(32'h1111_1111, 1'b1);
        send(32'h0006_0002, 1'b1);
        send(32'h2222_2222, 1'b1);
        send(32'h0007_0003, 1'b1);
        send(32'h3333_3333, 1'b1);
        send(32'h0004_0000, 1'b1);
        expect_done("t2");
        check("t2_done_once", 32'(done_cnt - d0), 32'd1);
        check_writes("t2", 3, 32'h0005_0001, 32'h1111_1111, 32'h0006_0002,
                     32'h2222_2222, 32'h0007_0003, 32'h3333_3333);

        // Bad magic.
        send(32'hDEAD_0002, 1'b0);
        @(negedge clk);
        check("t3_error", 32'(error), 32'd1);
        check("t3_ready", 32'(ifc.in_ready), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_error_hold", 32'(error), 32'd1);
        check("t3_ready_hold", 32'(ifc.in_ready), 32'd0);
        check_writes("t3", 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        do_clear();
        send(32'hC0F1_0001, 1'b0);
        send(32'h0006_0009, 1'b0);
        send(32'hCAFE_F00D, 1'b0);
        send(32'hCAF8_F004, 1'b0);
        expect_done("t3b");
        check_writes("t3b", 1, 32'h0006_0009, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 32'h0);

        // Wrong checksum, with clear asserted on the mismatching edge.
        d0 = done_cnt;
        send(32'hC0F1_0001, 1'b0);
        send(32'h0004_0007, 1'b0);
        send(32'h0000_00AA, 1'b0);
        clear = 1'b1;
        send(32'h0000_0000, 1'b0);
        clear = 1'b0;
        @(negedge clk);
        check("t4_error", 32'(error), 32'd1);
        check("t4_ready", 32'(ifc.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("t4_error_hold", 32'(error), 32'd1);
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check_writes("t4", 1, 32'h0004_0007, 32'h0000_00AA, 32'h0, 32'h0, 32'h0, 32'h0);
        do_clear();

        // Empty frames: good and bad checksum.
        send(32'hC0F1_0000, 1'b0);
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'd1);
        send(32'h0000_0000, 1'b0);
        expect_done("t5");
        d0 = done_cnt;
        send(32'hC0F1_0000, 1'b0);
        send(32'h0000_0001, 1'b0);
        @(negedge clk);
        check("t5b_error", 32'(error), 32'd1);
        check("t5b_no_done", 32'(done_cnt - d0), 32'd0);
        check_writes("t5", 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        do_clear();

        // Reset during the write cycle.
        send(32'hC0F1_0001, 1'b0);
        send(32'h0007_0005, 1'b0);
        send(32'h0000_0009, 1'b0);
        reset = 1'b0;
        #1;
        check("t6_rst_write", 32'(ifc.config_write), 32'd0);
        check("t6_rst_addr", ifc.config_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        check("t6_ready", 32'(ifc.in_ready), 32'd1);
        send(32'h0007_0005, 1'b0);
        @(negedge clk);
        check("t6_error", 32'(error), 32'd1);
        check_writes("t6", 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        do_clear();

        check("idle_bus", 32'(idle_viol), 32'd0);
        check("ready_in_write", 32'(ready_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/config_loader.md
# config_loader

Configuration master for the tile array: accepts a word stream of configuration frames over a valid/ready interface and drives the shared `config_addr`/`config_data` bus that every tile's address matchers decode. Each frame is a header, N (address, data) pairs and an XOR checksum. Sits between the off-chip bitstream source and the array's configuration bus; tiles see one single-cycle write per pair.

## Interface
Parameters:
- `MAGIC`, 16'hC0F1: required value of header bits [31:16].
- `IDLE_ADDR`, 32'h0000_0000: bus address driven when no write is in progress. Module id 0 matches no module, since flags 4–7 are the only valid ones.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = in reset).
- `in_data`  in  32  stream word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `clear`  in  1  leaves the ERROR state and clears sticky status.
- `config_addr`  out  32  bus address. Bits {mod_id[31:16], tile_id[15:0]}.
- `config_data`  out  32  bus data.
- `config_write`  out  1  high for exactly the cycle in which `config_addr`/`config_data` carry a write.
- `busy`  out  1  a frame is in progress (state is not HDR and not ERROR).
- `done`  out  1  one-cycle pulse when a frame's checksum matches.
- `error`  out  1  sticky flag: bad magic or checksum mismatch.

## Operation
- Transfer occurs on a rising edge with `in_valid && in_ready`. `in_ready` is decoded from state: it is 1 in HDR, ADDR, DATA and CHECK, and 0 in WRITE and ERROR.
- States:
  - HDR: wait for the header word.
    - Bits [31:16] != `MAGIC` → ERROR.
    - Otherwise latch `count = [15:0]`, clear `csum` and `busy` goes high.
    - If count == 0, go to CHECK; else go to ADDR.
  - ADDR: latch the address word, `csum ^= word`, go to DATA.
  - DATA: latch the data word, `csum ^= word`, go to WRITE.
  - WRITE: one cycle only. Outputs show the latched addr/data with `config_write`=1. Decrement `count`; if it reaches 0 go to CHECK, else go to ADDR.
  - CHECK: on the word, if it equals `csum`, pulse `done` and go to HDR; else set `error` and go to ERROR.
  - ERROR: ignore the stream (`in_ready`=0) until `clear`=1, then go to HDR with `error` cleared.
- Writes already issued before a checksum mismatch are not rolled back. Only `error` reports it.
- Outside WRITE, `config_addr` = `IDLE_ADDR`, `config_data` = 0 and `config_write` = 0.
- The pair counter is 16 bits, so a frame carries 0 to 65535 pairs. The decrement never wraps because a count of 0 skips the pair loop.
- `clear` has no effect outside ERROR. `clear` in the same cycle as a CHECK mismatch has no effect; the block still enters ERROR.
- `in_data` is ignored in any cycle where `in_valid`=0. Back-pressure stalls are unlimited.

## Timing
- Reset (`reset`=0), asynchronous:
  - state = HDR, count = 0, csum = 0.
  - `config_addr` = `IDLE_ADDR`, `config_data` = 0, `config_write` = 0.
  - `done` = 0, `error` = 0, `busy` = 0.
  - `in_ready` = 1 (decoded from HDR).
- Reset mid-frame aborts the frame. No partial write is issued after reset. The next accepted word is treated as a header.
- All bus outputs and the status flags are registered.
- Latency from a data word accepted at edge k:
  - `config_write` is high in the cycle after edge k.
  - `in_ready` is low in that same cycle.
  - The next address can be accepted at edge k+2.
  - Peak throughput is one write per 3 cycles.
- `done` is high in the cycle after the checksum word is accepted. A new header can be accepted in that same cycle.
- `error` rises the cycle after the offending word is accepted. It holds until the edge where `clear`=1 in ERROR.

## Structure
- Shared config package holds:
  - the state enum `loader_state_t` (HDR, ADDR, DATA, WRITE, CHECK, ERROR);
  - the address field constants: tile_id [15:0], mod_id [31:16];
  - the module flag constants: CLB = 4, CB1 = 5, CB0 = 6, SB = 7.
- No sub-module is needed. A single FSM holds the count/csum datapath.

## Test plan
- Single pair. Send 32'hC0F1_0001, then 32'h0004_0003, then 32'h0000_0002, then checksum 32'h0004_0001.
  - Exactly one cycle has `config_write`=1, with addr 32'h0004_0003 and data 32'h0000_0002.
  - `done` pulses one cycle later than the checksum word is accepted.
  - `error`=0.
- Three pairs with `in_valid` toggled randomly each cycle.
  - Three writes occur in order.
  - `in_ready`=0 in each write cycle.
  - Bus is at `IDLE_ADDR` otherwise.
  - `done` pulses once.
- Bad magic header 32'hDEAD_0002.
  - No write occurs.
  - `error`=1 and `in_ready`=0 until `clear`.
  - After `clear`, a valid frame loads normally.
- Wrong checksum on a one-pair frame.
  - The write is still issued.
  - Then `error`=1 and `done` never pulses.
- Empty frame: 32'hC0F1_0000, then checksum 32'h0.
  - No write and `done` pulses.
  - With checksum 32'h1 instead, `error`=1.
- Assert `reset`=0 in the cycle after a data word is accepted.
  - `config_write` is forced to 0 immediately.
  - After release, state is HDR: an address-like word 32'h0007_0005 is rejected as a bad header and `error`=1.
